// File: rtl/dma_bram_responder.sv
// Block-RAM responder for the bsg_cache DMA interface: serves block read fills and
// absorbs write evictions, one packet at a time, from a single-port synchronous RAM.
module dma_bram_responder #(
    parameter int caddr_width_p    = 28,
    parameter int dma_data_width_p = 64,
    parameter int block_width_p    = 512,
    parameter int mem_els_p        = 8192
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [caddr_width_p:0]      dma_pkt_i,
    input  logic                        dma_pkt_v_i,
    output logic                        dma_pkt_yumi_o,
    output logic [dma_data_width_p-1:0] dma_data_o,
    output logic                        dma_data_v_o,
    input  logic                        dma_data_ready_and_i,
    input  logic [dma_data_width_p-1:0] dma_data_i,
    input  logic                        dma_data_v_i,
    output logic                        dma_data_yumi_o
);

    localparam int beats_lp     = block_width_p / dma_data_width_p;
    localparam int lg_beats_lp  = $clog2(beats_lp);
    localparam int cnt_w_lp     = (beats_lp == 1) ? 1 : lg_beats_lp;
    localparam int lg_blk_b_lp  = $clog2(block_width_p / 8);
    localparam int lg_els_lp    = $clog2(mem_els_p);
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(beats_lp - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } state_e;

    state_e                        r_state;
    state_e                        w_state_next;
    logic [cnt_w_lp-1:0]           r_cnt;
    logic [lg_els_lp-1:0]          r_base;
    logic [dma_data_width_p-1:0]   r_rdata;
    logic [dma_data_width_p-1:0]   r_mem [mem_els_p];

    logic [caddr_width_p-1:0]      w_addr;
    logic                          w_is_write;
    logic [lg_els_lp-1:0]          w_pkt_base;
    logic [lg_els_lp-1:0]          w_ram_addr;
    logic                          w_ram_en;
    logic                          w_ram_we;
    logic                          w_cnt_inc;
    logic                          w_last;

    assign w_addr     = dma_pkt_i[caddr_width_p-1:0];
    assign w_is_write = dma_pkt_i[caddr_width_p];
    // Block number scaled to beats; truncation to the RAM index width makes large addresses wrap.
    assign w_pkt_base = lg_els_lp'((w_addr >> lg_blk_b_lp) << lg_beats_lp);
    assign w_last     = (r_cnt == last_cnt_lp);
    assign dma_data_v_o = (r_state == ST_READ);
    assign dma_data_o   = r_rdata;

    always_comb begin
        w_state_next    = r_state;
        dma_pkt_yumi_o  = 1'b0;
        dma_data_yumi_o = 1'b0;
        w_ram_en        = 1'b0;
        w_ram_we        = 1'b0;
        w_ram_addr      = r_base + lg_els_lp'(r_cnt);
        w_cnt_inc       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                dma_pkt_yumi_o = dma_pkt_v_i;
                if (dma_pkt_v_i) begin
                    if (w_is_write) begin
                        w_state_next = ST_WRITE;
                    end else begin
                        // Beat 0 is fetched in the accept cycle so it is valid one cycle later.
                        w_ram_en     = 1'b1;
                        w_ram_addr   = w_pkt_base;
                        w_state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (dma_data_ready_and_i) begin
                    if (w_last) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cnt_inc  = 1'b1;
                        w_ram_en   = 1'b1;
                        w_ram_addr = r_base + lg_els_lp'(r_cnt + cnt_w_lp'(1));
                    end
                end
            end
            ST_WRITE: begin
                dma_data_yumi_o = dma_data_v_i;
                if (dma_data_v_i) begin
                    w_ram_en  = 1'b1;
                    w_ram_we  = 1'b1;
                    w_cnt_inc = 1'b1;
                    if (w_last) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        // Nothing is accepted or touched in RAM while reset is held.
        if (reset_i) begin
            dma_pkt_yumi_o  = 1'b0;
            dma_data_yumi_o = 1'b0;
            w_ram_en        = 1'b0;
            w_ram_we        = 1'b0;
            w_cnt_inc       = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (dma_pkt_yumi_o) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + cnt_w_lp'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (dma_pkt_yumi_o) begin
            r_base <= w_pkt_base;
        end
    end

    // Single-port RAM; the read register holds when no read is issued.
    always_ff @(posedge clk_i) begin
        if (w_ram_en) begin
            if (w_ram_we) begin
                r_mem[w_ram_addr] <= dma_data_i;
            end else begin
                r_rdata <= r_mem[w_ram_addr];
            end
        end
    end

endmodule

// File: tb/tb_dma_bram_responder.sv
// Directed bench for dma_bram_responder: block writes/reads, backpressure, wrap, gaps, reset abort.
module tb_dma_bram_responder;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [28:0] dma_pkt_i;
    logic        dma_pkt_v_i;
    logic        dma_pkt_yumi_o;
    logic [63:0] dma_data_o;
    logic        dma_data_v_o;
    logic        dma_data_ready_and_i;
    logic [63:0] dma_data_i;
    logic        dma_data_v_i;
    logic        dma_data_yumi_o;

    int tests = 0;
    int fails = 0;

    dma_bram_responder dut (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .dma_pkt_i            (dma_pkt_i),
        .dma_pkt_v_i          (dma_pkt_v_i),
        .dma_pkt_yumi_o       (dma_pkt_yumi_o),
        .dma_data_o           (dma_data_o),
        .dma_data_v_o         (dma_data_v_o),
        .dma_data_ready_and_i (dma_data_ready_and_i),
        .dma_data_i           (dma_data_i),
        .dma_data_v_i         (dma_data_v_i),
        .dma_data_yumi_o      (dma_data_yumi_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Accepts a write packet, then presents beats base+k in the cycles where gap_mask has a 1.
    task automatic write_block(input logic [27:0] addr, input logic [63:0] base,
                               input logic [15:0] gap_mask, input logic hold_next);
        int k;
        dma_pkt_i   = {1'b1, addr};
        dma_pkt_v_i = 1'b1;
        #1 check("wr_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd1);
        tick();
        dma_pkt_v_i = hold_next;
        if (hold_next) dma_pkt_i = {1'b0, 28'h0000040};
        k = 0;
        for (int c = 0; c < 16 && k < 8; c++) begin
            dma_data_v_i = gap_mask[c];
            dma_data_i   = gap_mask[c] ? base + 64'(k) : 64'hDEAD_BEEF_DEAD_BEEF;
            #1;
            check("wr_data_yumi", 64'(dma_data_yumi_o), 64'(gap_mask[c]));
            check("wr_pkt_blocked", 64'(dma_pkt_yumi_o), 64'd0);
            if (gap_mask[c]) k++;
            tick();
        end
        check("wr_beats_done", 64'(k), 64'd8);
        dma_data_v_i = 1'b0;
    endtask

    // Consumes 8 beats; ready follows ready_mode (0: always high, 1: pattern 1,0,0 repeating).
    task automatic read_beats(input logic [63:0] base, input int ready_mode);
        int k;
        int c;
        k = 0;
        c = 0;
        while (k < 8 && c < 40) begin
            dma_data_ready_and_i = (ready_mode == 0) ? 1'b1 : (c % 3 == 0);
            #1;
            check("rd_v", 64'(dma_data_v_o), 64'd1);
            check("rd_data", dma_data_o, base + 64'(k));
            if (dma_data_ready_and_i) k++;
            c++;
            tick();
        end
        check("rd_handshakes", 64'(k), 64'd8);
        dma_data_ready_and_i = 1'b0;
        #1 check("rd_v_drop", 64'(dma_data_v_o), 64'd0);
    endtask

    task automatic read_pkt(input logic [27:0] addr);
        dma_pkt_i   = {1'b0, addr};
        dma_pkt_v_i = 1'b1;
        #1;
        check("rd_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd1);
        check("rd_v_accept_cycle", 64'(dma_data_v_o), 64'd0);
        tick();
        dma_pkt_v_i = 1'b0;
    endtask

    initial begin
        reset_i              = 1'b1;
        dma_pkt_i            = '0;
        dma_pkt_v_i          = 1'b0;
        dma_data_ready_and_i = 1'b0;
        dma_data_i           = '0;
        dma_data_v_i         = 1'b0;
        @(negedge clk_i);
        tick();
        dma_pkt_v_i  = 1'b1;
        dma_data_v_i = 1'b1;
        #1;
        check("rst_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
        check("rst_data_v", 64'(dma_data_v_o), 64'd0);
        check("rst_data_yumi", 64'(dma_data_yumi_o), 64'd0);
        tick();
        reset_i      = 1'b0;
        dma_pkt_v_i  = 1'b0;
        dma_data_v_i = 1'b1;
        #1 check("idle_data_yumi", 64'(dma_data_yumi_o), 64'd0);
        dma_data_v_i = 1'b0;

        // 1: back-to-back write then full-speed read
        write_block(28'h0000040, 64'h1111_0000, 16'h00FF, 1'b0);
        read_pkt(28'h0000040);
        read_beats(64'h1111_0000, 0);

        // 2: same block under 1,0,0 backpressure
        read_pkt(28'h0000040);
        read_beats(64'h1111_0000, 1);

        // 3: unaligned write address maps to the same block
        write_block(28'h0000047, 64'h3333_0000, 16'h00FF, 1'b0);
        read_pkt(28'h0000040);
        read_beats(64'h3333_0000, 0);

        // 4: address beyond 64 KiB wraps onto block 0x40
        write_block(28'h0010040, 64'h4444_0000, 16'h00FF, 1'b0);
        read_pkt(28'h0000040);
        read_beats(64'h4444_0000, 0);

        // 5: gapped write beats with a read packet waiting behind it
        write_block(28'h0000040, 64'h5555_0000, 16'b0000_1110_1100_1101, 1'b1);
        dma_data_v_i = 1'b1;
        dma_data_i   = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        check("next_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd1);
        check("idle_no_consume", 64'(dma_data_yumi_o), 64'd0);
        tick();
        dma_pkt_v_i  = 1'b0;
        dma_data_v_i = 1'b0;
        read_beats(64'h5555_0000, 0);

        // 6: reset after three read beats aborts the transfer
        read_pkt(28'h0000040);
        dma_data_ready_and_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 check("abort_pre_data", dma_data_o, 64'h5555_0000 + 64'(k));
            tick();
        end
        reset_i = 1'b1;
        tick();
        reset_i      = 1'b0;
        dma_data_v_i = 1'b1;
        #1;
        check("abort_v", 64'(dma_data_v_o), 64'd0);
        check("abort_data_yumi", 64'(dma_data_yumi_o), 64'd0);
        check("abort_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
        dma_data_v_i         = 1'b0;
        dma_data_ready_and_i = 1'b0;
        read_pkt(28'h0000040);
        read_beats(64'h5555_0000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dma_bram_responder.md
# dma_bram_responder

Responder end of the bsg_cache DMA interface. It accepts DMA packets from the unicore's L2 cache and serves read fills and write evictions out of on-chip block RAM. It drops in where the DDR3 controller normally sits: for DRAM-less bring-up, simulation, and small-program runs. It is single-clock, running on the core clock, and needs no calibration or clock crossing.

## Interface
Parameters:
- caddr_width_p, 28, byte address width carried in the DMA packet
- dma_data_width_p, 64, width of one DMA data beat (l2_fill_width_p)
- block_width_p, 512, cache block size in bits; beats per block N = block_width_p/dma_data_width_p (power of two, ≥1)
- mem_els_p, 8192, RAM depth in beats (power of two); capacity = mem_els_p*dma_data_width_p/8 bytes

Ports:
- clk_i  in  1  core clock
- reset_i  in  1  synchronous, active-high reset
- dma_pkt_i  in  caddr_width_p+1  {write_not_read (MSB), addr[caddr_width_p-1:0]}
- dma_pkt_v_i  in  1  packet valid
- dma_pkt_yumi_o  out  1  packet consumed this cycle
- dma_data_o  out  dma_data_width_p  read fill beat
- dma_data_v_o  out  1  read beat valid
- dma_data_ready_and_i  in  1  cache accepts read beat
- dma_data_i  in  dma_data_width_p  write beat
- dma_data_v_i  in  1  write beat valid
- dma_data_yumi_o  out  1  write beat consumed this cycle

## Operation
- Storage: single-port synchronous RAM, mem_els_p × dma_data_width_p, 1-cycle read latency. The RAM output holds its value when no read is enabled.
- Block base index = (addr >> log2(block_width_p/8)) * N, modulo mem_els_p. Low block-offset address bits are ignored. Addresses beyond capacity wrap.
- Beat counter: log2(N) bits (1 bit if N=1). Cleared on packet accept. The RAM index is the block base plus the count.
- FSM states: IDLE, READ, WRITE.
  - IDLE: dma_pkt_yumi_o = dma_pkt_v_i. On accept, latch the block base and clear the counter.
    - Read packet: issue the RAM read of beat 0 in the same cycle, then go to READ.
    - Write packet: go to WRITE.
  - READ: dma_data_v_o = 1 and dma_data_o = RAM output.
    - On handshake (v & ready) with count < N-1: increment the counter and issue the RAM read of the next beat in the same cycle.
    - On handshake with count = N-1: go to IDLE.
    - With no handshake: issue no read, so the beat holds stable.
  - WRITE: dma_data_yumi_o = dma_data_v_i. Each consumed beat is written to base+count and the counter increments.
    - Consuming beat N-1 returns the FSM to IDLE.
- Packets are not accepted outside IDLE. Write beats are never consumed outside WRITE, and data presented early waits.
- One transaction at a time. A write fully commits before the next packet is accepted, so a subsequent read of the same block returns the new data.
- The RAM is never cleared by reset; its contents are undefined until written.

## Timing
- Reset: state IDLE, counter 0, dma_pkt_yumi_o = 0, dma_data_v_o = 0, dma_data_yumi_o = 0. dma_data_o is don't-care while dma_data_v_o = 0.
- Reset asserted mid-transaction aborts it next cycle: no further beats are produced or consumed.
  - Beats already written stay in RAM.
  - The aborted packet is not replayed.
- Read latency: packet accepted in cycle t; beat 0 is valid at t+1.
- With ready held high, beats k = 0..N-1 handshake at t+1+k.
- The FSM is IDLE at t+N+1, so the next packet is accepted no earlier than t+N+1.
- Backpressure: while ready is low, dma_data_o and dma_data_v_o hold. The beat completes in the cycle ready rises.
- Write: packet accepted at t. Beats are consumed from t+1, one per cycle while dma_data_v_i is high, each written at the edge ending its consume cycle.
- After the last beat is consumed at cycle u, the FSM is IDLE at u+1.
- Yumi outputs are combinational from their valid inputs and state. dma_data_v_o is driven from state only, with no input path.

## Test plan
1. Reset, then write pkt addr 0x0000040 with 8 beats 0x1111_0000+k on consecutive cycles → yumi on cycles t+1..t+8. Read pkt 0x0000040 with ready high → beats 0x1111_0000..0x1111_0007 on t+1..t+8, v drops at t+9.
2. Read of addr 0x0000040 with ready toggling 1,0,0,1,… → each beat value is stable while ready = 0, no beat is skipped or duplicated, and exactly 8 handshakes occur.
3. Write pkt to addr 0x0000047 (unaligned), then read addr 0x0000040 → same block returned, beat 0 first.
4. Write to addr 0x0010040 with mem_els_p = 8192 (64 KiB, wraps to 0x0000040), then read 0x0000040 → the wrapped data is returned.
5. Write pkt with dma_data_v_i gapped (beats at cycles 1,3,4,7,…), plus a second pkt_v held high throughout → the second pkt yumi fires only in the cycle after the 8th beat, and no write beat is consumed while IDLE.
6. Assert reset_i after 3 of 8 read beats → next cycle v = 0 and yumi = 0. A fresh read then returns the full block from beat 0.
